// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue control slice: opcodes, ALU
// operations, the control bundle layout and the issue state machine states.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds the HALT state).
package decode_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SRL  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Control bundle latched by the Decode/Execute register; all-zero is a bubble
  typedef struct packed {
    logic       wbs;
    logic       wme;
    logic       mm;
    logic [2:0] ALUop;
    logic       wm;
    logic       am;
    logic       ni;
  } ctrl_bundle_t;

  // Issue state machine states
  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
`ifdef DECODE_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

endpackage

// File: rtl/decode_issue_control_opcode_decoder.sv
// Purely combinational opcode decoder: produces the control bundle for an
// opcode plus flags telling whether rs2 is read and whether the opcode is
// illegal (E/F decode as NOP here; trapping is decided by the top module).
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [3:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         uses_rs2,
  output logic         is_illegal
);

  // Opcode table lookup with an all-zero default bundle
  always_comb begin
    ctrl       = '0;
    uses_rs2   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_ADD; uses_rs2 = 1'b1; end
      OP_SUB: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_SUB; uses_rs2 = 1'b1; end
      OP_AND: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_AND; uses_rs2 = 1'b1; end
      OP_OR:  begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_OR;  uses_rs2 = 1'b1; end
      OP_XOR: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_XOR; uses_rs2 = 1'b1; end
      OP_SLL: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_SLL; uses_rs2 = 1'b1; end
      OP_SRL: begin ctrl.wm = 1'b1; ctrl.ALUop = ALU_SRL; uses_rs2 = 1'b1; end
      OP_ADDI: begin
        ctrl.wm    = 1'b1;
        ctrl.am    = 1'b1;
        ctrl.ALUop = ALU_ADD;
      end
      OP_LD: begin
        ctrl.mm    = 1'b1;
        ctrl.wbs   = 1'b1;
        ctrl.wm    = 1'b1;
        ctrl.am    = 1'b1;
        ctrl.ALUop = ALU_ADD;
      end
      OP_ST: begin
        ctrl.wme   = 1'b1;
        ctrl.am    = 1'b1;
        ctrl.ALUop = ALU_ADD;
        uses_rs2   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.ni    = 1'b1;
        ctrl.ALUop = ALU_SUB;
        uses_rs2   = 1'b1;
      end
      OP_JMP: begin
        ctrl.ni    = 1'b1;
        ctrl.ALUop = ALU_PASS;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_control.sv
// Decode-side issue control: decodes the Fetch/Decode instruction, tracks the
// instruction in Execute, inserts bubbles on load-use hazards and after taken
// branches, and drives stall/flush toward the PC and Fetch/Decode register.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal_out port, HALT state).
module decode_issue_control
  import decode_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int FLUSH_CYCLES = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid_in,
  input  logic [3:0]        opcode_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [REG_AW-1:0] rs1_in,
  input  logic [REG_AW-1:0] rs2_in,
  input  logic              branch_taken_in,
  output logic              wbs_out,
  output logic              wme_out,
  output logic              mm_out,
  output logic [2:0]        ALUop_out,
  output logic              wm_out,
  output logic              am_out,
  output logic              ni_out,
  output logic              stall_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic              illegal_out,
`endif
  output logic              flush_out
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t            state, state_next;
  logic [2:0]        cnt, cnt_next;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_load;
  ctrl_bundle_t      dec, bundle;
  logic              uses_rs2, is_illegal;
  logic              hazard, issue, stall, flush;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  opcode_decoder u_decoder (
    .opcode     (opcode_in),
    .ctrl       (dec),
    .uses_rs2   (uses_rs2),
    .is_illegal (is_illegal)
  );

  // Load-use hazard against the load currently in Execute (r0 never hazards)
  always_comb begin
    hazard = instr_valid_in & ex_load & (ex_rd != '0) &
             ((ex_rd == rs1_in) | (uses_rs2 & (ex_rd == rs2_in)));
  end

  // Next-state logic and bubble muxing; a taken branch outranks everything but HALT
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bundle     = '0;
    stall      = 1'b0;
    flush      = 1'b0;
    issue      = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
    if (state == S_HALT) begin
      stall   = 1'b1;
      illegal = 1'b1;
    end else
`endif
    if (branch_taken_in) begin
      flush      = 1'b1;
      cnt_next   = FLUSH_RELOAD;
      state_next = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    end else if (state == S_FLUSH) begin
      flush    = 1'b1;
      cnt_next = cnt - 3'd1;
      if (cnt <= 3'd1) begin
        cnt_next   = 3'd0;
        state_next = S_RUN;
      end
    end else if (!instr_valid_in) begin
      state_next = S_RUN;
`ifdef DECODE_ILLEGAL_TRAP_EN
    end else if (is_illegal) begin
      state_next = S_HALT;
`endif
    end else if (hazard && state == S_RUN) begin
      stall      = 1'b1;
      state_next = S_STALL;
    end else begin
      bundle     = dec;
      issue      = ~is_illegal;
      state_next = S_RUN;
    end
    if (rst) begin
      bundle     = '0;
      stall      = 1'b0;
      flush      = 1'b0;
      issue      = 1'b0;
      state_next = S_RUN;
      cnt_next   = 3'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal    = 1'b0;
`endif
    end
  end

  // State, flush counter and Execute-stage tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      cnt     <= 3'd0;
      ex_rd   <= '0;
      ex_load <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ex_rd   <= issue ? rd_in : '0;
      ex_load <= issue & dec.mm;
    end
  end

  // Output fan-out of the selected bundle and pipeline controls
  always_comb begin
    wbs_out     = bundle.wbs;
    wme_out     = bundle.wme;
    mm_out      = bundle.mm;
    ALUop_out   = bundle.ALUop;
    wm_out      = bundle.wm;
    am_out      = bundle.am;
    ni_out      = bundle.ni;
    stall_out   = stall;
    flush_out   = flush;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_out = illegal;
`endif
  end

endmodule

// File: tb/tb_decode_issue_control.sv
// Directed self-checking bench for decode_issue_control.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (checks the HALT trap).
module tb_decode_issue_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid_in;
  logic [3:0] opcode_in;
  logic [3:0] rd_in, rs1_in, rs2_in;
  logic       branch_taken_in;
  logic       wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
  logic [2:0] ALUop_out;
  logic       stall_out, flush_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic       illegal_out;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  decode_issue_control #(.REG_AW(4), .FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid_in  (instr_valid_in),
    .opcode_in       (opcode_in),
    .rd_in           (rd_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .branch_taken_in (branch_taken_in),
    .wbs_out         (wbs_out),
    .wme_out         (wme_out),
    .mm_out          (mm_out),
    .ALUop_out       (ALUop_out),
    .wm_out          (wm_out),
    .am_out          (am_out),
    .ni_out          (ni_out),
    .stall_out       (stall_out),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_out     (illegal_out),
`endif
    .flush_out       (flush_out)
  );

  // Expected output vector: {wbs, wme, mm, ALUop, wm, am, ni, stall, flush}
  function automatic logic [10:0] mk(input bit wbs, input bit wme, input bit mm,
                                     input logic [2:0] alu, input bit wm, input bit am,
                                     input bit ni, input bit stall, input bit flush);
    return {wbs, wme, mm, alu, wm, am, ni, stall, flush};
  endfunction

  function automatic logic [10:0] observed();
    return {wbs_out, wme_out, mm_out, ALUop_out, wm_out, am_out, ni_out, stall_out, flush_out};
  endfunction

  localparam logic [10:0] BUBBLE = 11'd0;
  localparam logic [10:0] STALLB = 11'b000_000_000_10;
  localparam logic [10:0] FLUSHB = 11'b000_000_000_01;

  task automatic checkOutput(input string tag, input logic [10:0] got, input logic [10:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, let logic settle before checks
  task automatic applyStimulus(input bit r, input bit v, input logic [3:0] op,
                               input logic [3:0] rd, input logic [3:0] rs1,
                               input logic [3:0] rs2, input bit br);
    @(negedge clk);
    rst             = r;
    instr_valid_in  = v;
    opcode_in       = op;
    rd_in           = rd;
    rs1_in          = rs1;
    rs2_in          = rs2;
    branch_taken_in = br;
    #1;
  endtask

  initial begin
    logic [10:0] ldB, addB, addiB, subB, beqB, stB, jmpB, xorB;
    ldB   = mk(1, 0, 1, 3'd0, 1, 1, 0, 0, 0);
    addB  = mk(0, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    addiB = mk(0, 0, 0, 3'd0, 1, 1, 0, 0, 0);
    subB  = mk(0, 0, 0, 3'd1, 1, 0, 0, 0, 0);
    beqB  = mk(0, 0, 0, 3'd1, 0, 0, 1, 0, 0);
    stB   = mk(0, 1, 0, 3'd0, 0, 1, 0, 0, 0);
    jmpB  = mk(0, 0, 0, 3'd7, 0, 0, 1, 0, 0);
    xorB  = mk(0, 0, 0, 3'd4, 1, 0, 0, 0, 0);

    // Reset held for two cycles with a valid LD at the inputs
    applyStimulus(1, 1, 4'h9, 4'd3, 4'd1, 4'd0, 0);
    checkOutput("reset_c0", observed(), BUBBLE);
    applyStimulus(1, 1, 4'h9, 4'd3, 4'd1, 4'd0, 1);
    checkOutput("reset_c1_br", observed(), BUBBLE);
`ifdef DECODE_ILLEGAL_TRAP_EN
    checkOutput("reset_illegal", {10'd0, illegal_out}, 11'd0);
`endif

    // First LD after release, then dependent ADD stalls once
    applyStimulus(0, 1, 4'h9, 4'd3, 4'd1, 4'd0, 0);
    checkOutput("first_ld", observed(), ldB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd3, 4'd2, 0);
    checkOutput("loaduse_stall", observed(), STALLB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd3, 4'd2, 0);
    checkOutput("loaduse_release", observed(), addB);

    // r0 is never a hazard source
    applyStimulus(0, 1, 4'h9, 4'd0, 4'd1, 4'd0, 0);
    checkOutput("ld_r0", observed(), ldB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd0, 4'd0, 0);
    checkOutput("no_hazard_r0", observed(), addB);

    // rs2 of ADDI is not read
    applyStimulus(0, 1, 4'h9, 4'd3, 4'd1, 4'd0, 0);
    checkOutput("ld_r3", observed(), ldB);
    applyStimulus(0, 1, 4'h8, 4'd5, 4'd4, 4'd3, 0);
    checkOutput("addi_rs2_unused", observed(), addiB);

    // rs2 of R-type is read
    applyStimulus(0, 1, 4'h9, 4'd6, 4'd1, 4'd0, 0);
    checkOutput("ld_r6", observed(), ldB);
    applyStimulus(0, 1, 4'h2, 4'd7, 4'd1, 4'd6, 0);
    checkOutput("sub_rs2_stall", observed(), STALLB);
    applyStimulus(0, 1, 4'h2, 4'd7, 4'd1, 4'd6, 0);
    checkOutput("sub_release", observed(), subB);

    // Branch resolves taken: exactly two flush bubbles
    applyStimulus(0, 1, 4'hB, 4'd0, 4'd1, 4'd2, 0);
    checkOutput("beq_decode", observed(), beqB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd2, 1);
    checkOutput("flush_1", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd2, 0);
    checkOutput("flush_2", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd2, 0);
    checkOutput("flush_done", observed(), addB);

    // Load-use hazard coinciding with a taken branch: flush wins
    applyStimulus(0, 1, 4'h9, 4'd7, 4'd1, 4'd0, 0);
    checkOutput("ld_r7", observed(), ldB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd7, 4'd0, 1);
    checkOutput("hazard_and_branch", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd7, 4'd0, 0);
    checkOutput("hazard_branch_flush2", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd7, 4'd0, 0);
    checkOutput("hazard_branch_resume", observed(), addB);

    // A second taken branch during FLUSH reloads the counter
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 1);
    checkOutput("reload_a", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 1);
    checkOutput("reload_b", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("reload_c", observed(), FLUSHB);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("reload_done", observed(), addB);

    // Remaining opcode patterns and an empty Fetch/Decode register
    applyStimulus(0, 1, 4'hA, 4'd0, 4'd2, 4'd3, 0);
    checkOutput("st_decode", observed(), stB);
    applyStimulus(0, 1, 4'hD, 4'd0, 4'd2, 4'd3, 0);
    checkOutput("jmp_decode", observed(), jmpB);
    applyStimulus(0, 1, 4'h5, 4'd8, 4'd2, 4'd3, 0);
    checkOutput("xor_decode", observed(), xorB);
    applyStimulus(0, 0, 4'h1, 4'd8, 4'd2, 4'd3, 0);
    checkOutput("invalid_bubble", observed(), BUBBLE);

    // Reset in the middle of FLUSH aborts it
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 1);
    checkOutput("pre_reset_flush", observed(), FLUSHB);
    applyStimulus(1, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("reset_in_flush", observed(), BUBBLE);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("after_reset_flush", observed(), addB);

    // Illegal opcode 0xE
`ifdef DECODE_ILLEGAL_TRAP_EN
    applyStimulus(0, 1, 4'hE, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("illegal_enter", observed(), BUBBLE);
    checkOutput("illegal_enter_flag", {10'd0, illegal_out}, 11'd0);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 1);
    checkOutput("halt_ignores_branch", observed(), STALLB);
    checkOutput("halt_flag", {10'd0, illegal_out}, 11'd1);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("halt_held", observed(), STALLB);
    applyStimulus(1, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("halt_reset", observed(), BUBBLE);
    checkOutput("halt_reset_flag", {10'd0, illegal_out}, 11'd0);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("halt_exit", observed(), addB);
`else
    applyStimulus(0, 1, 4'hE, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("illegal_as_nop", observed(), BUBBLE);
    applyStimulus(0, 1, 4'h1, 4'd5, 4'd1, 4'd0, 0);
    checkOutput("after_illegal", observed(), addB);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
